subservient_sram_arbiter: RTL

Two-port arbiter that shares the single byte-wide SRAM of the subservient SoC between the CPU memory port (port 0) and a loader/debug DMA port (port 1). Each cycle it grants at most one byte access, drives the SRAM read/write interface from the winner, and returns read data to the winner one cycle later, aligned with the SRAM's registered read. Round-robin fairness applies, with optional bounded burst locking so the loader can stream without being interleaved.

---
 rtl/subservient_arb_pkg.sv | 16 +
 rtl/subservient_rr_pick.sv | 38 +++
 rtl/subservient_sram_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/subservient_arb_pkg.sv
// Shared definitions for the subservient SRAM arbiter.
//   arb_state_t : burst-lock FSM state (IDLE, LOCK0, LOCK1)
//   PORT_CPU    : index of the CPU memory port (port 0)
//   PORT_DMA    : index of the loader/debug DMA port (port 1)
package subservient_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/subservient_rr_pick.sv
// Two-way combinational round-robin picker with lock override.
//   req0, req1 : requests from port 0 / port 1
//   last       : index of the port granted most recently
//   state      : current burst-lock state
//   gnt0, gnt1 : one-hot (or zero) grant
// A lone requester always wins; a lock only decides contention.
module subservient_rr_pick
  import subservient_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  arb_state_t state,
  output logic       gnt0,
  output logic       gnt1
);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      unique case (state)
        LOCK0: gnt0 = 1'b1;
        LOCK1: gnt1 = 1'b1;
        default: begin
          // The port that did not win last time takes this one.
          gnt0 = (last == PORT_DMA);
          gnt1 = (last == PORT_CPU);
        end
      endcase
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/subservient_sram_arbiter.sv
// Shares the single byte-wide SRAM between the CPU port (0) and the
// loader/debug DMA port (1).
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_req*/i_we*/i_addr*/
//   i_wdata*/i_lock*           : per-port access request
//   o_gnt0, o_gnt1             : combinational grant, same cycle as request
//   o_rdata                    : SRAM read data, shared by both ports
//   o_rvalid0, o_rvalid1       : read data valid for that port (cycle after grant)
//   o_sram_*                   : SRAM write/read interface
//   i_sram_rdata               : SRAM registered read data
// Round-robin between ports, with an optional lock that lets one port keep
// winning contention for up to max_burst consecutive grants.
module subservient_sram_arbiter
  import subservient_arb_pkg::*;
#(
  parameter int aw        = 9,
  parameter int max_burst = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [aw-1:0] i_addr0,
  input  logic [aw-1:0] i_addr1,
  input  logic [7:0]    i_wdata0,
  input  logic [7:0]    i_wdata1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic [7:0]    o_rdata,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [aw-1:0] o_sram_waddr,
  output logic [aw-1:0] o_sram_raddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  input  logic [7:0]    i_sram_rdata
);

  localparam logic [7:0] BURST_MAX = 8'(max_burst);

  arb_state_t state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       last_q, last_d;
  logic       pick_gnt0, pick_gnt1;
  logic [7:0] burst_inc;

  subservient_rr_pick u_pick (
    .req0  (i_req0),
    .req1  (i_req1),
    .last  (last_q),
    .state (state_q),
    .gnt0  (pick_gnt0),
    .gnt1  (pick_gnt1)
  );

  // Grants are gated by reset so no access (and no SRAM write) can be
  // accepted while reset is asserted, even mid-cycle.
  assign o_gnt0 = pick_gnt0 & i_rst_n;
  assign o_gnt1 = pick_gnt1 & i_rst_n;

  assign burst_inc = burst_cnt_q + 8'd1;

  // Burst-lock FSM: next state, burst counter and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;

    if (o_gnt0)      last_d = PORT_CPU;
    else if (o_gnt1) last_d = PORT_DMA;

    unique case (state_q)
      IDLE: begin
        // A limit of one grant means a lock can never extend past the
        // granting cycle, so the FSM stays in IDLE.
        if (o_gnt0 && i_lock0 && (BURST_MAX > 8'd1)) begin
          state_d     = LOCK0;
          burst_cnt_d = 8'd1;
        end else if (o_gnt1 && i_lock1 && (BURST_MAX > 8'd1)) begin
          state_d     = LOCK1;
          burst_cnt_d = 8'd1;
        end
      end

      LOCK0: begin
        if (!i_req0) begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
          last_d      = PORT_CPU;
        end else if (o_gnt0) begin
          if (!i_lock0 || (burst_inc == BURST_MAX)) begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
            last_d      = PORT_CPU;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end
      end

      LOCK1: begin
        if (!i_req1) begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
          last_d      = PORT_DMA;
        end else if (o_gnt1) begin
          if (!i_lock1 || (burst_inc == BURST_MAX)) begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
            last_d      = PORT_DMA;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= 8'd0;
      last_q      <= PORT_DMA;
      o_rvalid0   <= 1'b0;
      o_rvalid1   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      // Valid lines up with the SRAM's one-cycle registered read.
      o_rvalid0   <= o_gnt0 & ~i_we0;
      o_rvalid1   <= o_gnt1 & ~i_we1;
    end
  end

  // SRAM drive: port 1 only when it holds the grant, port 0 otherwise.
  always_comb begin
    if (o_gnt1) begin
      o_sram_waddr = i_addr1;
      o_sram_raddr = i_addr1;
      o_sram_wdata = i_wdata1;
    end else begin
      o_sram_waddr = i_addr0;
      o_sram_raddr = i_addr0;
      o_sram_wdata = i_wdata0;
    end
  end

  assign o_sram_wen = (o_gnt0 & i_we0) | (o_gnt1 & i_we1);
  assign o_rdata    = i_sram_rdata;

endmodule
